// File: rtl/uart_rx_deframer_pkg.sv
// Shared types and helpers for the UART receive deframer.
// State encoding, word-length codes and oversampling default.
package uart_rx_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WLS_5 = 2'b00,
    WLS_6 = 2'b01,
    WLS_7 = 2'b10,
    WLS_8 = 2'b11
  } wls_t;

  function automatic logic [3:0] wls_to_len(
    input logic [1:0] w
  );
    return 4'd5 + {2'b00, w};
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Line, configuration and FIFO-side signals of the RX deframer.
// master = deframer side, slave = line/config/FIFO side.
interface uart_rx_deframer_if;
  import uart_rx_pkg::*;

  logic       baud_tick;
  logic       rx_serial;
  logic [1:0] wls;
  logic       parity_en;
  logic       parity_even;
  logic       rx_fifo_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       start_bit_error;
  logic       parity_bit_error;
  logic       framing_stop_error;
  logic       overrun_error;
  logic       rx_busy;

  modport master (
    input  baud_tick, rx_serial, wls,
    input  parity_en, parity_even,
    input  rx_fifo_full,
    output rx_data, rx_valid,
    output start_bit_error,
    output parity_bit_error,
    output framing_stop_error,
    output overrun_error, rx_busy
  );

  modport slave (
    output baud_tick, rx_serial, wls,
    output parity_en, parity_even,
    output rx_fifo_full,
    input  rx_data, rx_valid,
    input  start_bit_error,
    input  parity_bit_error,
    input  framing_stop_error,
    input  overrun_error, rx_busy
  );

endinterface

// File: rtl/uart_rx_deframer_sync_edge.sv
// Two-flop synchronizer for the idle-high RX line
// with a falling-edge detect on the synchronized value.
module uart_rx_sync_edge
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
      prev <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      prev <= sync[1];
    end
  end

  assign dout = sync[1];
  assign fall = prev & ~sync[1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start detect, 5-8 data bits LSB-first,
// optional parity, stop check, one FIFO write per frame.
module uart_rx_deframer
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int CNT_W      = 4
) (
  input logic m_clk,
  input logic reset,
  uart_rx_deframer_if.master bus
);

  localparam logic [CNT_W-1:0] HALF =
    CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(OVERSAMPLE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic [3:0]       len;
  logic             pen;
  logic             peven;
  logic             par_err;
  logic             armed;
  logic             rx_s;
  logic             fall;

  logic [7:0] data_q;
  logic       valid_q;
  logic       se_q;
  logic       pe_q;
  logic       fe_q;
  logic       ovr_q;
  logic       busy_q;

  uart_rx_sync_edge u_sync (
    .clk   (m_clk),
    .reset (reset),
    .din   (bus.rx_serial),
    .dout  (rx_s),
    .fall  (fall)
  );

  always_ff @(posedge m_clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      len     <= 4'd8;
      pen     <= 1'b0;
      peven   <= 1'b0;
      par_err <= 1'b0;
      armed   <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      se_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (bus.baud_tick && !rx_s && (armed || fall)) begin
            state  <= START;
            cnt    <= '0;
            len    <= wls_to_len(bus.wls);
            pen    <= bus.parity_en;
            peven  <= bus.parity_even;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (bus.baud_tick) begin
            if (cnt == HALF) begin
              cnt <= '0;
              if (rx_s) begin
                se_q   <= 1'b1;
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                state <= DATA;
                idx   <= '0;
                shreg <= '0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (bus.baud_tick) begin
            if (cnt == LAST) begin
              cnt        <= '0;
              shreg[idx] <= rx_s;
              idx        <= idx + 3'd1;
              if ({1'b0, idx} == len - 4'd1)
                state <= pen ? PARITY : STOP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (bus.baud_tick) begin
            if (cnt == LAST) begin
              cnt     <= '0;
              // shreg is zero above the word, so ^shreg covers data only
              par_err <= ^shreg ^ rx_s ^ ~peven;
              state   <= STOP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (bus.baud_tick) begin
            if (cnt == LAST) begin
              cnt    <= '0;
              state  <= IDLE;
              busy_q <= 1'b0;
              fe_q   <= ~rx_s;
              pe_q   <= pen & par_err;
              se_q   <= 1'b0;
              if (!bus.rx_fifo_full) begin
                valid_q <= 1'b1;
                data_q  <= shreg;
              end else begin
                ovr_q <= 1'b1;
              end
              if (!rx_s) armed <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data            = data_q;
  assign bus.rx_valid           = valid_q;
  assign bus.start_bit_error    = se_q;
  assign bus.parity_bit_error   = pe_q;
  assign bus.framing_stop_error = fe_q;
  assign bus.overrun_error      = ovr_q;
  assign bus.rx_busy            = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: directed frames
// plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

  typedef struct {
    logic [7:0] word;
    logic       pe;
    logic       fe;
    logic       full;
    int         stop_tick;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_q = 1'b0;
  logic tick_q = 1'b0;
  int   tick_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [7:0] last_data = 8'h00;

  uart_rx_deframer_if bus ();

  uart_rx_deframer #(.OVERSAMPLE(16), .CNT_W(4)) dut (
    .m_clk (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_q    <= reset;
    tick_q   <= bus.baud_tick;
    tick_cnt <= tick_cnt + int'(bus.baud_tick);
  end

  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      int sp;
      sp = $urandom_range(5, 3);
      repeat (sp - 1) @(negedge clk);
      bus.baud_tick = 1'b1;
      @(negedge clk);
      bus.baud_tick = 1'b0;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Compare process: pulses, flags and data against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_q) begin
        last_data = 8'h00;
        chk("reset_state",
            {bus.rx_data, bus.rx_valid, bus.start_bit_error,
             bus.parity_bit_error, bus.framing_stop_error,
             bus.overrun_error, bus.rx_busy}, 32'h0);
      end else if (bus.rx_valid || bus.overrun_error) begin
        chk("pulse_excl",
            32'(bus.rx_valid & bus.overrun_error), 0);
        if (q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind", {bus.rx_valid, bus.overrun_error},
              {~e.full, e.full});
          chk("pulse_timing", {tick_q, 31'(tick_cnt)},
              {1'b1, 31'(e.stop_tick)});
          chk("frame_flags",
              {bus.start_bit_error, bus.parity_bit_error,
               bus.framing_stop_error}, {1'b0, e.pe, e.fe});
          if (!e.full) last_data = e.word;
          chk("frame_data", bus.rx_data, last_data);
        end
      end else begin
        chk("data_hold", bus.rx_data, last_data);
      end
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (bus.baud_tick !== 1'b1);
    #1;
  endtask

  task automatic send_bit(input logic v);
    bus.rx_serial = v;
    repeat (16) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] data,
                            input logic [1:0] w,
                            input logic pen, input logic pev,
                            input logic flip, input logic stop,
                            input logic full, input int gap,
                            input logic scr);
    exp_t e;
    int   nb;
    logic pbit;
    nb = 5 + int'(w);
    e.word = data & 8'((1 << nb) - 1);
    pbit = (^e.word) ^ ~pev ^ flip;
    e.pe = pen && (((^e.word) ^ pbit) != !pev);
    e.fe = !stop;
    e.full = full;
    e.stop_tick = tick_cnt + 9 + 16 * (nb + int'(pen) + 1);
    bus.wls = w;
    bus.parity_en = pen;
    bus.parity_even = pev;
    bus.rx_fifo_full = full;
    q.push_back(e);
    send_bit(1'b0);
    if (scr) begin
      bus.wls = 2'($urandom);
      bus.parity_en = 1'($urandom);
      bus.parity_even = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) send_bit(data[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
    repeat (gap) send_bit(1'b1);
    chk("frame_delivered", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.rx_serial = 1'b1;
    bus.wls = 2'b11;
    bus.parity_en = 1'b0;
    bus.parity_even = 1'b0;
    bus.rx_fifo_full = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (20) wait_tick();

    send_frame(8'hA5, 2'b11, 0, 0, 0, 1, 0, 1, 0);
    chk("8n1_data", bus.rx_data, 8'hA5);
    chk("8n1_flags", {bus.start_bit_error, bus.parity_bit_error,
                      bus.framing_stop_error}, 0);

    send_frame(8'h35, 2'b10, 1, 1, 0, 1, 0, 1, 0);
    chk("7e1_data", bus.rx_data, 8'h35);
    chk("7e1_pe_ok", bus.parity_bit_error, 0);
    send_frame(8'h35, 2'b10, 1, 1, 1, 1, 0, 1, 0);
    chk("7e1_pe_bad", bus.parity_bit_error, 1);

    bus.rx_serial = 1'b0;
    repeat (4) wait_tick();
    bus.rx_serial = 1'b1;
    repeat (16) wait_tick();
    chk("false_start_se", bus.start_bit_error, 1);
    chk("false_start_busy", bus.rx_busy, 0);
    send_frame(8'h5A, 2'b11, 0, 0, 0, 1, 0, 1, 0);
    chk("after_fs_se", bus.start_bit_error, 0);
    chk("after_fs_data", bus.rx_data, 8'h5A);

    send_frame(8'h3C, 2'b11, 0, 0, 0, 0, 0, 2, 0);
    chk("framing_fe", bus.framing_stop_error, 1);
    chk("framing_data", bus.rx_data, 8'h3C);

    bus.wls = 2'b11;
    bus.parity_en = 1'b0;
    e.word = 8'h00;
    e.pe = 1'b0;
    e.fe = 1'b1;
    e.full = 1'b0;
    e.stop_tick = tick_cnt + 9 + 16 * 9;
    q.push_back(e);
    bus.rx_serial = 1'b0;
    repeat (3 * 10 * 16) wait_tick();
    bus.rx_serial = 1'b1;
    repeat (48) wait_tick();
    chk("break_delivered", q.size(), 0);
    chk("break_data", bus.rx_data, 8'h00);
    chk("break_fe_hold", bus.framing_stop_error, 1);

    send_frame(8'h81, 2'b11, 0, 0, 0, 1, 1, 1, 0);
    chk("overrun_data_kept", bus.rx_data, 8'h00);
    bus.rx_fifo_full = 1'b0;

    bus.wls = 2'b11;
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    bus.rx_serial = 1'b1;
    repeat (8) wait_tick();
    chk("busy_mid_frame", bus.rx_busy, 1);
    do_reset();
    chk("busy_after_reset", bus.rx_busy, 0);
    repeat (40) wait_tick();

    send_frame(8'h0D, 2'b00, 0, 0, 0, 1, 0, 1, 0);
    chk("5n1_data", bus.rx_data, 8'h0D);

    for (int k = 0; k < 30; k++) begin
      logic stop, pen;
      int   gap;
      stop = ($urandom_range(7, 0) != 0);
      pen = 1'($urandom);
      gap = $urandom_range(2, stop ? 0 : 1);
      send_frame(8'($urandom), 2'($urandom), pen,
                 1'($urandom), pen && ($urandom_range(3, 0) == 0),
                 stop, ($urandom_range(5, 0) == 0), gap,
                 ($urandom_range(2, 0) == 0));
    end
    bus.rx_fifo_full = 1'b0;
    repeat (20) wait_tick();
    chk("end_idle", {bus.rx_busy, 31'(q.size())}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side serial deframer of the UART. It oversamples the asynchronous RX line and detects the start bit.
- It shifts in 5–8 data bits LSB-first, checks the optional parity bit and the stop bit.
- On each completed frame it writes one word into the RX FIFO.
- Its per-frame status flags (start_bit_error, parity_bit_error, framing_stop_error) feed the line status register directly.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and ≥4.
- CNT_W, 4, width of the tick counter; must satisfy 2^CNT_W ≥ OVERSAMPLE.

Ports:
- m_clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-m_clk-wide enable at OVERSAMPLE × baud rate.
- rx_serial  input  1  asynchronous serial input; idle high.
- wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits.
- parity_en  input  1  1 = a parity bit follows the data.
- parity_even  input  1  1 = even parity, 0 = odd parity.
- rx_fifo_full  input  1  RX FIFO full (wr_full_RX).
- rx_data  output  8  received word, zero-extended above wls length.
- rx_valid  output  1  one-cycle RX FIFO write strobe.
- start_bit_error  output  1  false start detected.
- parity_bit_error  output  1  parity mismatch in last frame.
- framing_stop_error  output  1  stop bit sampled low in last frame.
- overrun_error  output  1  one-cycle pulse: frame dropped because FIFO full.
- rx_busy  output  1  high while state ≠ IDLE.

Behaviour:
- **Reset (synchronous, active-high).** Wins over all other activity, including mid-frame.
  - State ← IDLE, tick counter ← 0.
  - Synchronizer flops ← 1, armed ← 1.
  - rx_data ← 8'h00; rx_valid, overrun_error, start_bit_error, parity_bit_error, framing_stop_error, rx_busy ← 0.
- **Synchronizer.** rx_serial passes through 2 flops (rx_s). Falling edge = rx_s==0 with previous rx_s==1. Synchronizer latency is 2 m_clk.
- **IDLE.**
  - If armed and rx_s==0 on a baud_tick: go to START, counter ← 0.
  - At that same point latch wls, parity_en and parity_even. Config changes mid-frame have no effect until the next frame.
  - armed ← 1 whenever rx_s==1 in IDLE.
- **START.** Counts baud_ticks only; the counter holds between ticks.
  - On the tick where counter == OVERSAMPLE/2−1 (mid-bit), sample rx_s.
  - If rx_s==1 (false start): start_bit_error ← 1, return to IDLE, no rx_valid.
  - Otherwise go to DATA, counter ← 0, bit index ← 0.
- **DATA.**
  - On the tick where counter == OVERSAMPLE−1: sample rx_s into shift bit [index], counter ← 0, index++.
  - After the N-th bit (N = latched word length): go to PARITY if parity enabled, else to STOP.
- **PARITY.** Sample at the same point (counter == OVERSAMPLE−1).
  - Error if XOR(data bits, parity bit) ≠ 0 for even parity, or ≠ 1 for odd parity.
- **STOP.** Sample at counter == OVERSAMPLE−1. Frame end (stop sample tick = T; all outputs updated on the m_clk edge following T):
  - rx_data ← assembled word, bits above N forced to 0.
  - framing_stop_error ← (stop sample == 0).
  - parity_bit_error ← parity result, or 0 if parity is disabled.
  - start_bit_error ← 0.
  - If rx_fifo_full == 0: rx_valid = 1 for exactly one cycle. Else: rx_valid = 0, overrun_error = 1 for one cycle, and rx_data is not updated.
  - State → IDLE at mid-stop-bit (half-bit resync margin).
  - If the stop sample was 0: armed ← 0, so a break or stuck-low line does not retrigger until the line returns high.
- **Flag hold.** The three error flags are levels; they hold until the next frame end or the next false start.
- **Break.** All-zero data plus a low stop bit gives rx_data = 0 with framing_stop_error = 1, delivered once per break.
- **baud_tick absent.** The FSM freezes in its current state.

Decomposition:
- Package uart_rx_pkg:
  - State encoding: IDLE, START, DATA, PARITY, STOP (3-bit).
  - WLS codes and a function wls_to_len(wls) returning 5..8.
  - OVERSAMPLE default constant.
- One natural sub-module, uart_rx_sync_edge: 2-flop synchronizer plus falling-edge detect, reset to 1.

Test Plan:
- **Basic 8N1.** Frame 0xA5 (wls=11, parity_en=0) at 16× tick → one rx_valid, rx_data=8'hA5, all error flags 0, rx_valid 1 cycle after the stop-sample tick.
- **7-bit even parity.** 7E1 frame 0x35 with a correct parity bit (0) → rx_data=8'h35, parity_bit_error=0. Same frame with the parity bit flipped → parity_bit_error=1, rx_valid still 1.
- **False start.** Low glitch of 4 ticks in IDLE → start_bit_error=1, no rx_valid, state back to IDLE. A following good 0x5A frame → start_bit_error=0, rx_data=8'h5A.
- **Framing and break.**
  - Frame 0x3C with stop bit low → framing_stop_error=1, rx_data=8'h3C.
  - Line held low for 3 frame times → exactly one rx_valid with rx_data=0 and framing_stop_error=1, then no further rx_valid until the line goes high and a new frame arrives.
- **Overrun.** rx_fifo_full=1 during the 0x81 stop sample → rx_valid=0, one-cycle overrun_error, rx_data unchanged.
- **Reset mid-frame and 5-bit word.**
  - Reset asserted mid-frame (during DATA bit 4) → all outputs 0 next cycle, state IDLE, rx_busy=0.
  - Then a 5N1 frame with data bits 10110 → rx_data=8'h0D.
